// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage miniRV pipeline: load-use bubbles, redirect squashes,
// dmem wait freezing with timeout, plus saturating retire/stall counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_wR_i,
    input  logic             ex_rf_we_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    input  logic             mem_req_i,
    input  logic             dmem_ready_i,
    input  logic             wb_null_i,
    input  logic             clr_cnt_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_stall_o,
    output logic             idex_flush_o,
    output logic             exmem_stall_o,
    output logic             memwb_null_o,
    output logic [1:0]       state_o,
    output logic             err_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    localparam logic [7:0]       WaitLast = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic load_use;
    logic freeze;

    // x0 is never a real producer, so it cannot create a hazard.
    assign load_use = ex_is_load_i && ex_rf_we_i && (ex_wR_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_i == ex_wR_i)) ||
                       (id_rs2_used_i && (id_rs2_i == ex_wR_i)));

    assign freeze = ((state_q == StRun) && mem_req_i && !dmem_ready_i) ||
                    ((state_q == StMemWait) && !dmem_ready_i) ||
                    (state_q == StErr);

    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_stall_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_stall_o = 1'b0;
        memwb_null_o  = 1'b0;
        if (rst_i) begin
            memwb_null_o = 1'b1;
        end else if (freeze) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_stall_o  = 1'b1;
            exmem_stall_o = 1'b1;
            memwb_null_o  = 1'b1;
        end else if (state_q == StRun) begin
            // A redirect makes the ID instruction wrong-path, so it beats load-use.
            if (ex_redirect_i) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (load_use) begin
                pc_stall_o   = 1'b1;
                ifid_stall_o = 1'b1;
                idex_flush_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        unique case (state_q)
            StRun: begin
                if (mem_req_i && !dmem_ready_i) begin
                    state_d = StMemWait;
                    wait_d  = 8'd1;
                end
            end
            StMemWait: begin
                if (dmem_ready_i) begin
                    state_d = StRun;
                    wait_d  = 8'd0;
                end else if (wait_q == WaitLast) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StErr: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = StErr;
                err_d   = 1'b1;
            end
        endcase
    end

    always_comb begin
        retire_d = retire_q;
        stall_d  = stall_q;
        if (clr_cnt_i) begin
            retire_d = '0;
            stall_d  = '0;
        end else begin
            if (!wb_null_i && (retire_q != CntMax)) begin
                retire_d = retire_q + 1'b1;
            end
            if (pc_stall_o && (stall_q != CntMax)) begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StRun;
            wait_q   <= 8'd0;
            err_q    <= 1'b0;
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
        end
    end

    assign state_o      = state_q;
    assign err_o        = err_q;
    assign retire_cnt_o = retire_q;
    assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences and
// randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int CW   = 4;
    localparam int TO   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rs1_used, rs2_used, rf_we, is_load, redirect;
    logic          mem_req, ready, wb_null, clr;
    logic [4:0]    rs1, rs2, wr;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
    logic          memwb_null, err;
    logic [1:0]    state;
    logic [CW-1:0] retire_cnt, stall_cnt;
    logic [6:0]    ctrl;

    assign ctrl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
                   memwb_null};

    pipe_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
        .ex_wR_i(wr), .ex_rf_we_i(rf_we), .ex_is_load_i(is_load), .ex_redirect_i(redirect),
        .mem_req_i(mem_req), .dmem_ready_i(ready), .wb_null_i(wb_null), .clr_cnt_i(clr),
        .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
        .idex_stall_o(idex_stall), .idex_flush_o(idex_flush), .exmem_stall_o(exmem_stall),
        .memwb_null_o(memwb_null), .state_o(state), .err_o(err),
        .retire_cnt_o(retire_cnt), .stall_cnt_o(stall_cnt)
    );

    // Output bit order: {pc, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem, memwb_null}
    localparam logic [6:0] CtrlReset  = 7'b0000001;
    localparam logic [6:0] CtrlFreeze = 7'b1101011;
    localparam logic [6:0] CtrlSquash = 7'b0010100;
    localparam logic [6:0] CtrlBubble = 7'b1100100;
    localparam logic [6:0] CtrlNone   = 7'b0000000;

    int vectors     = 0;
    int miscompares = 0;

    // Model: consecutive frozen memory cycles, sticky error, plain integer counters.
    int mrun  = 0;
    int mret  = 0;
    int mstl  = 0;
    bit merr  = 1'b0;
    bit mvalid = 1'b0;

    function automatic int mstate();
        if (merr) return 2;
        return (mrun > 0) ? 1 : 0;
    endfunction

    function automatic bit mem_frozen();
        if (merr) return 1'b1;
        if (mrun > 0) return !ready;
        return mem_req && !ready;
    endfunction

    function automatic logic [6:0] model_ctrl();
        bit hz;
        hz = is_load && rf_we && (wr != 5'd0) &&
             ((rs1_used && rs1 == wr) || (rs2_used && rs2 == wr));
        if (rst) return CtrlReset;
        if (mem_frozen()) return CtrlFreeze;
        if (mrun > 0) return CtrlNone;
        if (redirect) return CtrlSquash;
        if (hz) return CtrlBubble;
        return CtrlNone;
    endfunction

    task automatic model_edge(input logic [6:0] e);
        if (rst) begin
            mrun = 0; mret = 0; mstl = 0; merr = 1'b0; mvalid = 1'b1;
            return;
        end
        if (clr) begin
            mret = 0; mstl = 0;
        end else begin
            if (!wb_null) mret = (mret + 1 > CMAX) ? CMAX : mret + 1;
            if (e[6])     mstl = (mstl + 1 > CMAX) ? CMAX : mstl + 1;
        end
        if (!merr) begin
            if (mem_frozen()) begin
                mrun++;
                if (mrun == TO) merr = 1'b1;
            end else begin
                mrun = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Check everything against the model, then advance one clock.
    task automatic cycle(input string tag);
        logic [6:0] e;
        #1;
        e = model_ctrl();
        chk({tag, ".ctrl"}, 32'(ctrl), 32'(e));
        if (mvalid) begin
            chk({tag, ".state"},  32'(state),      mstate());
            chk({tag, ".err"},    32'(err),        32'(merr));
            chk({tag, ".retire"}, 32'(retire_cnt), mret);
            chk({tag, ".stall"},  32'(stall_cnt),  mstl);
        end
        @(posedge clk);
        model_edge(e);
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] wr;
        logic       we, ld, redir;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, CtrlBubble};
        tbl[1] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, CtrlNone};
        tbl[2] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, CtrlSquash};
        tbl[3] = '{5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, CtrlBubble};
        tbl[4] = '{5'd1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, CtrlNone};
        tbl[5] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, CtrlNone};
        tbl[6] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, CtrlNone};
        tbl[7] = '{5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, CtrlSquash};
        tbl[8] = '{5'd6, 5'd8, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, CtrlNone};

        rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; wr = 0; rf_we = 0; is_load = 0;
        redirect = 0; wb_null = 1; clr = 0;
        rst = 1; mem_req = 1; ready = 0;
        @(negedge clk);

        // Reset held two cycles with a pending, unready dmem request.
        repeat (2) begin
            #1 chk("rst.forced", 32'(ctrl), 32'(CtrlReset));
            cycle("rst");
        end
        rst = 0; mem_req = 0; ready = 1;
        #1;
        chk("rst.state",  32'(state), 0);
        chk("rst.retire", 32'(retire_cnt), 0);
        chk("rst.stall",  32'(stall_cnt), 0);

        // Three wait cycles then release.
        mem_req = 1; ready = 0;
        repeat (3) begin
            #1 chk("wait.frozen", 32'(ctrl), 32'(CtrlFreeze));
            cycle("wait");
        end
        ready = 1;
        #1 chk("wait.release", 32'(ctrl), 32'(CtrlNone));
        cycle("wait.rel");
        mem_req = 0;
        #1;
        chk("wait.state", 32'(state), 0);
        chk("wait.stallcnt", 32'(stall_cnt), 3);

        for (int i = 0; i < 9; i++) begin
            rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; rs1_used = tbl[i].u1; rs2_used = tbl[i].u2;
            wr = tbl[i].wr; rf_we = tbl[i].we; is_load = tbl[i].ld; redirect = tbl[i].redir;
            #1 chk($sformatf("tbl[%0d]", i), 32'(ctrl), 32'(tbl[i].exp));
            cycle("tbl");
        end
        rf_we = 0; is_load = 0; redirect = 0;

        // Timeout: four frozen cycles reach ERR; error survives ready and needs reset.
        mem_req = 1; ready = 0;
        repeat (TO) cycle("tmo");
        #1;
        chk("tmo.state", 32'(state), 2);
        chk("tmo.err",   32'(err), 1);
        mem_req = 0; ready = 1; redirect = 1;
        repeat (2) cycle("tmo.hold");
        #1;
        chk("tmo.sticky", 32'(err), 1);
        chk("tmo.frozen", 32'(ctrl), 32'(CtrlFreeze));
        redirect = 0; rst = 1;
        cycle("tmo.rst");
        rst = 0;
        #1;
        chk("tmo.recover", 32'(state), 0);
        chk("tmo.errclr",  32'(err), 0);

        // Retire saturation and clear-over-increment.
        wb_null = 0;
        repeat (20) cycle("sat");
        #1 chk("sat.retire", 32'(retire_cnt), CMAX);
        clr = 1;
        cycle("clr");
        clr = 0; wb_null = 1;
        #1;
        chk("clr.retire", 32'(retire_cnt), 0);
        chk("clr.stall",  32'(stall_cnt), 0);

        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(39) == 0) || (merr && $urandom_range(3) == 0);
            rs1      = 5'($urandom_range(3));
            rs2      = 5'($urandom_range(3));
            wr       = 5'($urandom_range(3));
            rs1_used = 1'($urandom);
            rs2_used = 1'($urandom);
            rf_we    = 1'($urandom);
            is_load  = 1'($urandom);
            redirect = ($urandom_range(4) == 0);
            mem_req  = ($urandom_range(3) == 0);
            ready    = ($urandom_range(2) != 0);
            wb_null  = 1'($urandom);
            clr      = ($urandom_range(29) == 0);
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage miniRV pipeline. It detects load-use hazards, squashes wrong-path instructions on branch/jump redirects, and freezes the pipeline during multi-cycle data-memory accesses. While the pipeline is frozen, it injects null bubbles into the MEM/WB register. It also keeps retire and stall performance counters, plus a sticky dmem-timeout error.

Parameters:
CNT_W, 32, width of retire/stall performance counters (saturating)
TIMEOUT, 16, max consecutive MEM_WAIT cycles before error (legal range 2..255)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
id_rs1_i  in  5  rs1 of instruction in ID
id_rs2_i  in  5  rs2 of instruction in ID
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
ex_wR_i  in  5  destination reg of instruction in EX
ex_rf_we_i  in  1  EX instruction writes register file
ex_is_load_i  in  1  EX instruction is a load
ex_redirect_i  in  1  taken branch/jump resolved in EX
mem_req_i  in  1  MEM-stage instruction accesses dmem this cycle
dmem_ready_i  in  1  dmem completes access this cycle
wb_null_i  in  1  null flag at MEM/WB output (1 = bubble)
clr_cnt_i  in  1  synchronous clear of both counters
pc_stall_o  out  1  hold PC
ifid_stall_o  out  1  hold IF/ID
ifid_flush_o  out  1  load null into IF/ID
idex_stall_o  out  1  hold ID/EX
idex_flush_o  out  1  load null into ID/EX
exmem_stall_o  out  1  hold EX/MEM
memwb_null_o  out  1  drive null_i=1 and rf_we_i=0 into MEM/WB
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
err_o  out  1  sticky dmem timeout
retire_cnt_o  out  CNT_W  retired instructions
stall_cnt_o  out  CNT_W  cycles with pc_stall_o=1

Behaviour:
- Reset (rst_i=1 at an edge):
  - state becomes RUN; wait_cnt, retire_cnt_o, stall_cnt_o and err_o become 0.
  - While rst_i=1, all stall/flush outputs are forced to 0 and memwb_null_o is forced to 1.
  - Reset mid-MEM_WAIT or in ERR returns to RUN on the next edge.
- Control outputs are combinational from state and inputs.
- Counters, state and wait_cnt are registered.
- Memory-freeze condition (freeze): (RUN and mem_req_i and !dmem_ready_i), or MEM_WAIT and !dmem_ready_i, or ERR.
  - freeze drives pc, ifid, idex and exmem stalls to 1, all flushes to 0, and memwb_null_o to 1.
- RUN state:
  - mem_req_i=1 and dmem_ready_i=1: zero-wait access, no stall, stay in RUN.
  - mem_req_i=1 and dmem_ready_i=0: freeze this cycle, go to MEM_WAIT, wait_cnt=1.
  - Otherwise, when not frozen, evaluate priorities below.
- MEM_WAIT state:
  - dmem_ready_i=1: freeze drops this cycle, memwb_null_o=0 so the access result is captured, go to RUN, wait_cnt=0.
  - dmem_ready_i=0 with wait_cnt=TIMEOUT-1: go to ERR and set err_o.
  - dmem_ready_i=0 otherwise: wait_cnt+1.
  - Redirect and load-use inputs are ignored in this state.
- ERR state: permanent freeze until rst_i; err_o stays 1.
- Priorities when not frozen (highest first):
  1. ex_redirect_i=1: ifid_flush_o=1, idex_flush_o=1, no stalls. This also overrides a simultaneous load-use, since the ID instruction is wrong-path.
  2. Load-use: ex_is_load_i and ex_rf_we_i and ex_wR_i!=0 and ((id_rs1_used_i and id_rs1_i==ex_wR_i) or (id_rs2_used_i and id_rs2_i==ex_wR_i)). Response: pc_stall_o=1, ifid_stall_o=1, idex_flush_o=1; exmem and memwb advance normally. Exactly 1 bubble per load-use pair.
  3. Otherwise all stall/flush outputs are 0 and memwb_null_o=0.
- x0 never causes a hazard.
- Counters:
  - retire_cnt increments each edge with wb_null_i=0.
  - stall_cnt increments each edge with pc_stall_o=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - clr_cnt_i=1 clears both to 0; it has priority over increment in the same cycle.

Test Plan:
- Reset: hold rst_i 2 cycles while dmem_ready_i=0 and mem_req_i=1 → state_o=0, counters 0, memwb_null_o=1, all stalls 0.
- Load-use: EX lw x5 (ex_wR_i=5, ex_is_load_i=1, ex_rf_we_i=1), ID add reads rs1=5 → exactly one cycle with pc_stall_o=ifid_stall_o=idex_flush_o=1. Repeat with ex_wR_i=0 → no stall.
- Redirect plus load-use in the same cycle → ifid_flush_o=idex_flush_o=1, pc_stall_o=0.
- dmem wait: mem_req_i=1, dmem_ready_i low for 3 cycles then high → 3 frozen cycles with memwb_null_o=1, release on the ready cycle, stall_cnt_o=3, state back to RUN.
- Timeout: TIMEOUT=4, dmem_ready_i held 0 → ERR after 4 frozen cycles, err_o=1 sticky even when ready rises; rst_i recovers to RUN.
- Counters: CNT_W=4, feed 20 cycles with wb_null_i=0 → retire_cnt_o saturates at 15. clr_cnt_i with a simultaneous retire → 0.
